// File: rtl/iddr_align_pkg.sv
// Shared definitions for the IDDR word aligner: FSM state encodings and width helpers.
package iddr_align_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_FAIL   = 2'd3;

    function automatic int beat_w(input int word_w);
        return (word_w / 2 > 1) ? $clog2(word_w / 2) : 1;
    endfunction

    function automatic int off_w(input int word_w);
        return $clog2(word_w);
    endfunction

endpackage

// File: rtl/iddr_lane_align.sv
// One lane of the aligner: 2-bit-per-clock shift register, bit offset search,
// training match counter and the word mux at the current offset.
module iddr_lane_align
    import iddr_align_pkg::*;
#(
    parameter int                WORD_W    = 8,
    parameter logic [WORD_W-1:0] TRAIN     = 8'h5C,
    parameter int                MATCH_CNT = 4,
    localparam int               OW        = off_w(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_r,
    input  logic              bit_f,
    input  logic              strobe,
    input  logic              search,
    input  logic              clear,
    output logic [WORD_W-1:0] word,
    output logic              lane_locked,
    output logic              lock_next,
    output logic [OW-1:0]     off
);

    localparam int              MW         = $clog2(MATCH_CNT + 1);
    localparam logic [MW-1:0]   MATCH_LAST = MW'(MATCH_CNT - 1);
    localparam logic [OW-1:0]   OFF_LAST   = OW'(WORD_W - 1);

    logic [2*WORD_W-1:0] sr;
    logic [2*WORD_W-1:0] sr_next;
    logic [MW-1:0]       match;
    logic                hit;

    // The word is taken from the post-shift value so the strobe cycle's own bits are included.
    assign sr_next   = {sr[2*WORD_W-3:0], bit_r, bit_f};
    assign word      = sr_next[off +: WORD_W];
    assign hit       = (word == TRAIN);
    assign lock_next = lane_locked | (search & strobe & hit & (match == MATCH_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr          <= '0;
            off         <= '0;
            match       <= '0;
            lane_locked <= 1'b0;
        end else begin
            sr <= sr_next;
            if (clear) begin
                off         <= '0;
                match       <= '0;
                lane_locked <= 1'b0;
            end else if (search && strobe && !lane_locked) begin
                if (hit) begin
                    match <= match + 1'b1;
                    if (match == MATCH_LAST)
                        lane_locked <= 1'b1;
                end else begin
                    match <= '0;
                    off   <= (off == OFF_LAST) ? '0 : off + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/iddr_word_align.sv
// Deserializes IDDR lane pairs into aligned words once every lane has locked on the training word.
//   state  | meaning
//   IDLE   | offsets/counters held at 0, waiting for align_en
//   SEARCH | per-lane offset hunt on each word strobe, timeout running
//   LOCKED | offsets frozen, aligned words emitted every strobe
//   FAIL   | search timed out, held until align_en drops
module iddr_word_align
    import iddr_align_pkg::*;
#(
    parameter int                LANES     = 4,
    parameter int                WORD_W    = 8,
    parameter logic [WORD_W-1:0] TRAIN     = 8'h5C,
    parameter int                MATCH_CNT = 4,
    parameter int                TIMEOUT   = 64,
    localparam int               OW        = off_w(WORD_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2*LANES-1:0]       q,
    input  logic                     align_en,
    output logic [LANES*WORD_W-1:0]  dout,
    output logic                     dout_valid,
    output logic                     locked,
    output logic                     align_fail,
    output logic [LANES-1:0]         lane_locked,
    output logic [LANES*OW-1:0]      off_dbg
);

    localparam int            BW        = beat_w(WORD_W);
    localparam logic [BW-1:0] BEAT_LAST = BW'(WORD_W / 2 - 1);
    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    logic [1:0]              state;
    logic [1:0]              state_n;
    logic [BW-1:0]           beat;
    logic [TW-1:0]           tmo;
    logic                    strobe;
    logic                    lane_clear;
    logic                    in_search;
    logic                    emit;
    logic [LANES-1:0]        lock_next;
    logic [LANES*WORD_W-1:0] word_all;

    assign strobe     = (beat == BEAT_LAST);
    assign lane_clear = (state == ST_IDLE) || !align_en;
    assign in_search  = (state == ST_SEARCH) && align_en;
    assign emit       = (state == ST_LOCKED) && align_en && strobe;
    assign locked     = (state == ST_LOCKED);
    assign align_fail = (state == ST_FAIL);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        iddr_lane_align #(
            .WORD_W    (WORD_W),
            .TRAIN     (TRAIN),
            .MATCH_CNT (MATCH_CNT)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .bit_r       (q[i]),
            .bit_f       (q[LANES+i]),
            .strobe      (strobe),
            .search      (in_search),
            .clear       (lane_clear),
            .word        (word_all[i*WORD_W +: WORD_W]),
            .lane_locked (lane_locked[i]),
            .lock_next   (lock_next[i]),
            .off         (off_dbg[i*OW +: OW])
        );
    end

    // Full lock is checked before the timeout so a lock on the last strobe still wins.
    always_comb begin
        state_n = state;
        if (!align_en) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state_n = ST_SEARCH;
                ST_SEARCH: begin
                    if (strobe) begin
                        if (&lock_next)
                            state_n = ST_LOCKED;
                        else if (tmo == TMO_LAST)
                            state_n = ST_FAIL;
                    end
                end
                default:   state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            beat       <= '0;
            tmo        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            state      <= state_n;
            beat       <= strobe ? '0 : beat + 1'b1;
            dout_valid <= emit;
            if (emit)
                dout <= word_all;
            if (lane_clear)
                tmo <= '0;
            else if (in_search && strobe)
                tmo <= tmo + 1'b1;
        end
    end

endmodule
